// File: rtl/mux4to1_pkg.sv
// Shared types and helpers for the registered 4:1 lane multiplexer.
// Optional feature macro used by the top level: MUX4TO1_PARITY_EN.
package mux4to1_pkg;

    localparam int MUX4_LANES = 4;

    typedef enum logic [1:0] {
        SEL_L0 = 2'b00,
        SEL_L1 = 2'b01,
        SEL_L2 = 2'b10,
        SEL_L3 = 2'b11
    } sel_e;

    // Selects one bit position of the chosen lane. The caller supplies the
    // same bit position from all four lanes, so applying this across every
    // bit yields the full WIDTH-bit lane without needing a width parameter
    // inside the package. Indexing directly with sel keeps X on the select
    // visible as X on the result instead of silently picking a lane.
    function automatic logic lane_of(input logic [MUX4_LANES-1:0] a_bits,
                                     input sel_e sel);
        return a_bits[sel];
    endfunction

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational 4:1 lane selector; no state, no reset.
// Lane n of a occupies a[n*WIDTH +: WIDTH].
module mux4_comb
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [MUX4_LANES*WIDTH-1:0] a,
    input  sel_e                        sel,
    output logic [WIDTH-1:0]            y
);

    // Gather each bit position across the four lanes and pick the selected one.
    always_comb begin
        logic [MUX4_LANES-1:0] column;
        y = '0;
        for (int b = 0; b < WIDTH; b++) begin
            column = '0;
            for (int n = 0; n < MUX4_LANES; n++) begin
                column[n] = a[n*WIDTH + b];
            end
            y[b] = lane_of(column, sel);
        end
    end

endmodule

// File: rtl/mux_4to1_sync.sv
// Registered 4:1 multiplexer: Q takes lane {s1,s0} of A one clock later.
// Synchronous active-high reset has priority over the capture enable.
// Define MUX4TO1_PARITY_EN to add the registered even-parity output q_par.
module mux_4to1_sync
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [MUX4_LANES*WIDTH-1:0] A,
    input  logic                        s0,
    input  logic                        s1,
`ifdef MUX4TO1_PARITY_EN
    output logic [WIDTH-1:0]            Q,
    output logic                        q_par
`else
    output logic [WIDTH-1:0]            Q
`endif
);

    sel_e             sel;
    logic [WIDTH-1:0] lane_sel;

    assign sel = sel_e'({s1, s0});

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_mux4_comb (
        .a   (A),
        .sel (sel),
        .y   (lane_sel)
    );

    // Output register: clear on reset, capture the selected lane when enabled, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= '0;
        end else if (en) begin
            Q <= lane_sel;
        end
    end

`ifdef MUX4TO1_PARITY_EN
    // Parity register tracks Q exactly: same reset, same enable, parity of the captured lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_par <= 1'b0;
        end else if (en) begin
            q_par <= ^lane_sel;
        end
    end
`endif

endmodule

// File: tb/tb_mux_4to1_sync.sv
// Self-checking bench for mux_4to1_sync: one WIDTH=1 and one WIDTH=8 instance
// share clock, reset, enable and select; a lane-array model is compared every cycle.
module tb_mux_4to1_sync;

    logic       clk;
    logic       rst;
    logic       en;
    logic       s0;
    logic       s1;
    logic [3:0]  a1;
    logic [31:0] a8;
    logic [0:0]  q1;
    logic [7:0]  q8;
`ifdef MUX4TO1_PARITY_EN
    logic       q_par1;
    logic       q_par8;
`endif

    int checks = 0;
    int errors = 0;

    logic [0:0] model_q1;
    logic [7:0] model_q8;
    logic       model_valid = 1'b0;

    mux_4to1_sync #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .A     (a1),
        .s0    (s0),
        .s1    (s1),
`ifdef MUX4TO1_PARITY_EN
        .Q     (q1),
        .q_par (q_par1)
`else
        .Q     (q1)
`endif
    );

    mux_4to1_sync #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .A     (a8),
        .s0    (s0),
        .s1    (s1),
`ifdef MUX4TO1_PARITY_EN
        .Q     (q8),
        .q_par (q_par8)
`else
        .Q     (q8)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lane n of a packed bus is simply the value shifted down by n lanes and masked.
    function automatic logic [7:0] pickLane(input logic [31:0] bus, input int width, input int n);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return 8'((bus >> (n * width)) & mask);
    endfunction

    function automatic logic evenParity(input logic [7:0] v);
        return logic'($countones(v) % 2);
    endfunction

    // Reference model: what Q must be after each edge, from the behavioural rules.
    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (rst) begin
            model_q1 <= '0;
            model_q8 <= '0;
        end else if (en) begin
            model_q1 <= 1'(pickLane({28'd0, a1}, 1, int'({s1, s0})));
            model_q8 <= pickLane(a8, 8, int'({s1, s0}));
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model_q1", {7'd0, q1}, {7'd0, model_q1});
            checkOutput("model_q8", q8, model_q8);
`ifdef MUX4TO1_PARITY_EN
            checkOutput("model_par1", {7'd0, q_par1}, {7'd0, evenParity({7'd0, model_q1})});
            checkOutput("model_par8", {7'd0, q_par8}, {7'd0, evenParity(model_q8)});
`endif
        end
    end

    // Drive one set of inputs away from the edge, then let one rising edge capture them.
    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] av1,
                                 input logic [31:0] av8, input logic [1:0] sel);
        rst = r;
        en  = e;
        a1  = av1;
        a8  = av8;
        {s1, s0} = sel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; a1 = '0; a8 = '0; s0 = 1'b0; s1 = 1'b0;
        @(negedge clk);

        // Reset for two edges with all-ones data and enable high: reset wins.
        applyStimulus(1'b1, 1'b1, 4'b1111, 32'hFFFF_FFFF, 2'b11);
        applyStimulus(1'b1, 1'b1, 4'b1111, 32'hFFFF_FFFF, 2'b11);
        checkOutput("reset_q1", {7'd0, q1}, 8'h00);
        checkOutput("reset_q8", q8, 8'h00);
`ifdef MUX4TO1_PARITY_EN
        checkOutput("reset_par8", {7'd0, q_par8}, 8'h00);
`endif

        // Each lane selected in turn, single-bit lanes.
        applyStimulus(1'b0, 1'b1, 4'b0001, 32'h0000_0000, 2'b00);
        checkOutput("sel00_q1", {7'd0, q1}, 8'h01);
        applyStimulus(1'b0, 1'b1, 4'b0010, 32'h0000_0000, 2'b01);
        checkOutput("sel01_q1", {7'd0, q1}, 8'h01);
        applyStimulus(1'b0, 1'b1, 4'b0100, 32'h0000_0000, 2'b10);
        checkOutput("sel10_q1", {7'd0, q1}, 8'h01);
        applyStimulus(1'b0, 1'b1, 4'b1000, 32'h0000_0000, 2'b11);
        checkOutput("sel11_q1", {7'd0, q1}, 8'h01);

        // Hot bit in a non-selected lane must not reach Q.
        applyStimulus(1'b0, 1'b1, 4'b0010, 32'h0000_0000, 2'b00);
        checkOutput("miss00_q1", {7'd0, q1}, 8'h00);
        applyStimulus(1'b0, 1'b1, 4'b0001, 32'h0000_0000, 2'b11);
        checkOutput("miss11_q1", {7'd0, q1}, 8'h00);

        // Hold with en low while A and sel move, then release.
        applyStimulus(1'b0, 1'b1, 4'b0001, 32'h0000_0000, 2'b00);
        checkOutput("prehold_q1", {7'd0, q1}, 8'h01);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 32'h0000_0000, 2'(s));
            checkOutput("hold_q1", {7'd0, q1}, 8'h01);
        end
        applyStimulus(1'b0, 1'b1, 4'b0000, 32'h0000_0000, 2'b11);
        checkOutput("release_q1", {7'd0, q1}, 8'h00);

        // Eight-bit lanes: {A5, 3C, 0F, FF} from lane 3 down to lane 0.
        applyStimulus(1'b0, 1'b1, 4'b0000, {8'hA5, 8'h3C, 8'h0F, 8'hFF}, 2'b10);
        checkOutput("w8_sel10", q8, 8'h3C);
`ifdef MUX4TO1_PARITY_EN
        checkOutput("w8_par10", {7'd0, q_par8}, 8'h00);
`endif
        applyStimulus(1'b0, 1'b1, 4'b0000, {8'hA5, 8'h3C, 8'h0F, 8'hFF}, 2'b11);
        checkOutput("w8_sel11", q8, 8'hA5);
`ifdef MUX4TO1_PARITY_EN
        checkOutput("w8_par11", {7'd0, q_par8}, 8'h00);
`endif
        applyStimulus(1'b0, 1'b1, 4'b0000, {8'hA5, 8'h3C, 8'h0F, 8'hFF}, 2'b01);
        checkOutput("w8_sel01", q8, 8'h0F);
        applyStimulus(1'b0, 1'b1, 4'b0000, {8'h11, 8'h07, 8'h80, 8'h5A}, 2'b10);
        checkOutput("w8_odd", q8, 8'h07);
`ifdef MUX4TO1_PARITY_EN
        checkOutput("w8_par_odd", {7'd0, q_par8}, 8'h01);
`endif
        applyStimulus(1'b0, 1'b0, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 2'b00);
        checkOutput("w8_hold", q8, 8'h07);
`ifdef MUX4TO1_PARITY_EN
        checkOutput("w8_par_hold", {7'd0, q_par8}, 8'h01);
`endif

        // Mid-stream reset clears on its edge; first capture follows on deassert.
        applyStimulus(1'b0, 1'b1, 4'b0100, {8'h00, 8'hC3, 8'h00, 8'h00}, 2'b10);
        checkOutput("pre_rst_q1", {7'd0, q1}, 8'h01);
        applyStimulus(1'b1, 1'b1, 4'b0100, {8'h00, 8'hC3, 8'h00, 8'h00}, 2'b10);
        checkOutput("mid_rst_q1", {7'd0, q1}, 8'h00);
        checkOutput("mid_rst_q8", q8, 8'h00);
        applyStimulus(1'b0, 1'b1, 4'b0100, {8'h00, 8'hC3, 8'h00, 8'h00}, 2'b10);
        checkOutput("post_rst_q1", {7'd0, q1}, 8'h01);
        checkOutput("post_rst_q8", q8, 8'hC3);

        // A few pseudo-random cycles for the every-cycle model comparison.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                          4'($urandom), $urandom, 2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
